// File: rtl/fdma_rw_arbiter_pkg.sv
// Shared types and constants for the FDMA read/write arbiter.
package fdma_rw_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_W_REQ = 3'd1,
    ST_W_RUN = 3'd2,
    ST_R_REQ = 3'd3,
    ST_R_RUN = 3'd4
  } arb_state_e;

  localparam int RD_BURST_LIMIT_DEF = 4;
  localparam int RD_CONSEC_W_DEF    = $clog2(RD_BURST_LIMIT_DEF + 1);

  // Width of the consecutive-read counter; it must be able to hold the limit itself.
  function automatic int rd_consec_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/fdma_arb_grant.sv
// Combinational grant decision: read has priority, except that a pending
// write is granted once RD_BURST_LIMIT reads have gone ahead of it.
module fdma_arb_grant
  import fdma_rw_arbiter_pkg::*;
#(
  parameter int RD_BURST_LIMIT = RD_BURST_LIMIT_DEF,
  parameter int CW             = rd_consec_width(RD_BURST_LIMIT)
) (
  input  logic          idle_i,
  input  logic          w_areq_i,
  input  logic          r_areq_i,
  input  logic [CW-1:0] rd_consec_i,
  output logic          grant_w_o,
  output logic          grant_r_o
);

  localparam logic [CW-1:0] LIMIT_C = CW'(RD_BURST_LIMIT);

  // Priority with starvation guard, evaluated only while the arbiter is idle.
  always_comb begin
    grant_w_o = 1'b0;
    grant_r_o = 1'b0;
    if (idle_i) begin
      if (r_areq_i && w_areq_i) begin
        if (rd_consec_i == LIMIT_C) grant_w_o = 1'b1;
        else                        grant_r_o = 1'b1;
      end else if (r_areq_i) begin
        grant_r_o = 1'b1;
      end else if (w_areq_i) begin
        grant_w_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdma_rw_arbiter.sv
// Arbitrates one write and one read requester onto a shared FDMA master port.
// Optional feature: define FDMA_ARB_STATS_EN to add 32-bit grant counters
// (stat_wr_cnt, stat_rd_cnt).
//
// state    | meaning
// IDLE     | no transfer; grant decision taken from current-cycle requests
// W_REQ    | write request presented, waiting for fdma_busy
// W_RUN    | write transfer running, waiting for fdma_busy to fall
// R_REQ    | read request presented, waiting for fdma_busy
// R_RUN    | read transfer running, waiting for fdma_busy to fall
module fdma_rw_arbiter
  import fdma_rw_arbiter_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 21,
  parameter int RD_BURST_LIMIT = 4
) (
  input  logic                      ui_clk,
  input  logic                      ui_rst,
  input  logic [AXI_ADDR_WIDTH-1:0] w_addr,
  input  logic                      w_areq,
  input  logic [15:0]               w_size,
  output logic                      w_busy,
  input  logic [AXI_DATA_WIDTH-1:0] w_wdata,
  output logic                      w_wvalid,
  input  logic [AXI_ADDR_WIDTH-1:0] r_addr,
  input  logic                      r_areq,
  input  logic [15:0]               r_size,
  output logic                      r_busy,
  output logic [AXI_DATA_WIDTH-1:0] r_rdata,
  output logic                      r_rvalid,
`ifdef FDMA_ARB_STATS_EN
  output logic [31:0]               stat_wr_cnt,
  output logic [31:0]               stat_rd_cnt,
`endif
  output logic [AXI_ADDR_WIDTH-1:0] fdma_addr,
  output logic                      fdma_areq,
  output logic                      fdma_rnw,
  output logic [15:0]               fdma_size,
  input  logic                      fdma_busy,
  output logic [AXI_DATA_WIDTH-1:0] fdma_wdata,
  input  logic                      fdma_wvalid,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
  input  logic                      fdma_rvalid
);

  localparam int            CW      = rd_consec_width(RD_BURST_LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(RD_BURST_LIMIT);

  arb_state_e                state_q, state_d;
  logic [CW-1:0]             rd_consec_q, rd_consec_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [15:0]               size_q;
  logic                      rnw_q;
  logic                      grant_w, grant_r;

  fdma_arb_grant #(
    .RD_BURST_LIMIT (RD_BURST_LIMIT),
    .CW             (CW)
  ) u_grant (
    .idle_i      (state_q == ST_IDLE),
    .w_areq_i    (w_areq),
    .r_areq_i    (r_areq),
    .rd_consec_i (rd_consec_q),
    .grant_w_o   (grant_w),
    .grant_r_o   (grant_r)
  );

  // Next-state: grants only leave IDLE, so the return cycle never grants.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_r)      state_d = ST_R_REQ;
        else if (grant_w) state_d = ST_W_REQ;
      end
      ST_W_REQ: if (fdma_busy)  state_d = ST_W_RUN;
      ST_W_RUN: if (!fdma_busy) state_d = ST_IDLE;
      ST_R_REQ: if (fdma_busy)  state_d = ST_R_RUN;
      ST_R_RUN: if (!fdma_busy) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Count reads that overtook a waiting write; a write grant resets the run.
  always_comb begin
    rd_consec_d = rd_consec_q;
    if (grant_w)
      rd_consec_d = '0;
    else if (grant_r && w_areq && (rd_consec_q != LIMIT_C))
      rd_consec_d = rd_consec_q + 1'b1;
  end

  // State, starvation counter and latched transfer descriptor.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state_q     <= ST_IDLE;
      rd_consec_q <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      rnw_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_consec_q <= rd_consec_d;
      if (grant_r) begin
        addr_q <= r_addr;
        size_q <= r_size;
        rnw_q  <= 1'b1;
      end else if (grant_w) begin
        addr_q <= w_addr;
        size_q <= w_size;
        rnw_q  <= 1'b0;
      end
    end
  end

  assign fdma_addr  = addr_q;
  assign fdma_size  = size_q;
  assign fdma_rnw   = rnw_q;
  assign fdma_areq  = (state_q == ST_W_REQ) || (state_q == ST_R_REQ);
  assign fdma_wdata = w_wdata;
  assign r_rdata    = fdma_rdata;

  assign w_busy   = ((state_q == ST_W_REQ) || (state_q == ST_W_RUN)) && fdma_busy;
  assign r_busy   = ((state_q == ST_R_REQ) || (state_q == ST_R_RUN)) && fdma_busy;
  assign w_wvalid = (state_q == ST_W_RUN) && fdma_wvalid;
  assign r_rvalid = (state_q == ST_R_RUN) && fdma_rvalid;

`ifdef FDMA_ARB_STATS_EN
  logic [31:0] stat_wr_cnt_q, stat_rd_cnt_q;

  // Grant counters, free-running with natural 32-bit wrap.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      stat_wr_cnt_q <= '0;
      stat_rd_cnt_q <= '0;
    end else begin
      if (grant_w) stat_wr_cnt_q <= stat_wr_cnt_q + 32'd1;
      if (grant_r) stat_rd_cnt_q <= stat_rd_cnt_q + 32'd1;
    end
  end

  assign stat_wr_cnt = stat_wr_cnt_q;
  assign stat_rd_cnt = stat_rd_cnt_q;
`endif

endmodule

// File: tb/tb_fdma_rw_arbiter.sv
// Directed bench for fdma_rw_arbiter; stats checks compile in with FDMA_ARB_STATS_EN.
module tb_fdma_rw_arbiter;

  localparam int DW = 32;
  localparam int AW = 21;

  logic          ui_clk = 1'b0;
  logic          ui_rst;
  logic [AW-1:0] w_addr, r_addr, fdma_addr;
  logic          w_areq, r_areq, fdma_areq, fdma_rnw;
  logic [15:0]   w_size, r_size, fdma_size;
  logic          w_busy, r_busy, fdma_busy;
  logic [DW-1:0] w_wdata, r_rdata, fdma_wdata, fdma_rdata;
  logic          w_wvalid, r_rvalid, fdma_wvalid, fdma_rvalid;
`ifdef FDMA_ARB_STATS_EN
  logic [31:0]   stat_wr_cnt, stat_rd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fdma_rw_arbiter #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .RD_BURST_LIMIT (4)
  ) dut (
    .ui_clk      (ui_clk),
    .ui_rst      (ui_rst),
    .w_addr      (w_addr),
    .w_areq      (w_areq),
    .w_size      (w_size),
    .w_busy      (w_busy),
    .w_wdata     (w_wdata),
    .w_wvalid    (w_wvalid),
    .r_addr      (r_addr),
    .r_areq      (r_areq),
    .r_size      (r_size),
    .r_busy      (r_busy),
    .r_rdata     (r_rdata),
    .r_rvalid    (r_rvalid),
`ifdef FDMA_ARB_STATS_EN
    .stat_wr_cnt (stat_wr_cnt),
    .stat_rd_cnt (stat_rd_cnt),
`endif
    .fdma_addr   (fdma_addr),
    .fdma_areq   (fdma_areq),
    .fdma_rnw    (fdma_rnw),
    .fdma_size   (fdma_size),
    .fdma_busy   (fdma_busy),
    .fdma_wdata  (fdma_wdata),
    .fdma_wvalid (fdma_wvalid),
    .fdma_rdata  (fdma_rdata),
    .fdma_rvalid (fdma_rvalid)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  // Wait (bounded) for the next request, then complete it with a one-cycle run.
  task automatic run_xfer(output logic rnw);
    bit seen = 1'b0;
    rnw = 1'bx;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fdma_areq) begin
        seen = 1'b1;
        break;
      end
    end
    chk("grant_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      rnw = fdma_rnw;
      fdma_busy = 1'b1;
      tick();
      fdma_busy = 1'b0;
      tick();
    end
  endtask

  task automatic do_one(input bit rd, output logic rnw);
    if (rd) r_areq = 1'b1;
    else    w_areq = 1'b1;
    run_xfer(rnw);
    r_areq = 1'b0;
    w_areq = 1'b0;
  endtask

  initial begin
    logic       rnw;
    int         wv_cnt;
    logic [9:0] exp_order;
    exp_order = 10'b1111011110;

    ui_rst = 1'b1;
    w_addr = '0; w_areq = 1'b0; w_size = '0; w_wdata = '0;
    r_addr = '0; r_areq = 1'b0; r_size = '0;
    fdma_busy = 1'b0; fdma_wvalid = 1'b0; fdma_rdata = '0; fdma_rvalid = 1'b0;
    repeat (3) tick();
    chk("rst_areq", fdma_areq, 0);
    chk("rst_addr", fdma_addr, 0);
    chk("rst_size", fdma_size, 0);
    chk("rst_rnw",  fdma_rnw,  0);
    ui_rst = 1'b0;
    tick();

    // single write of 256 words
    w_areq = 1'b1; w_addr = 21'h400; w_size = 16'd256;
    #1;
    chk("wr_areq_pre", fdma_areq, 0);
    tick();
    chk("wr_areq", fdma_areq, 1);
    chk("wr_rnw",  fdma_rnw,  0);
    chk("wr_addr", fdma_addr, 21'h400);
    chk("wr_size", fdma_size, 256);
    w_areq = 1'b0;
    fdma_busy = 1'b1;
    #1;
    chk("wr_busy_req", w_busy, 1);
    tick();
    chk("wr_areq_run", fdma_areq, 0);
    wv_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      fdma_wvalid = i[0];
      w_wdata = 32'hA500_0000 + i;
      #1;
      if (w_wvalid) wv_cnt++;
      if (i == 7) chk("wr_wdata", fdma_wdata, 32'hA500_0007);
      tick();
    end
    chk("wr_wvalid_cnt", wv_cnt, 256);
    fdma_wvalid = 1'b0;
    fdma_busy = 1'b0;
    tick();
    chk("wr_done_busy", w_busy, 0);
    chk("wr_held_addr", fdma_addr, 21'h400);

    // both requests held: R,R,R,R,W,R,R,R,R,W
    r_addr = 21'h100; r_size = 16'd8; w_addr = 21'h200; w_size = 16'd4;
    r_areq = 1'b1; w_areq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      run_xfer(rnw);
      chk($sformatf("order%0d", k), rnw, exp_order[9-k]);
    end
    r_areq = 1'b0; w_areq = 1'b0;
    tick();

    // read pulse during W_RUN is dropped; read data path stays quiet
    w_areq = 1'b1;
    tick();
    w_areq = 1'b0;
    fdma_busy = 1'b1;
    tick();
    r_areq = 1'b1;
    fdma_rvalid = 1'b1;
    fdma_wvalid = 1'b1;
    #1;
    chk("wrun_rvalid", r_rvalid, 0);
    chk("wrun_wvalid", w_wvalid, 1);
    tick();
    r_areq = 1'b0;
    fdma_rvalid = 1'b0;
    fdma_wvalid = 1'b0;
    chk("wrun_rbusy", r_busy, 0);
    chk("wrun_still", w_busy, 1);
    fdma_rvalid = 1'b1;
    #1;
    chk("wrun_rvalid2", r_rvalid, 0);
    fdma_rvalid = 1'b0;
    fdma_busy = 1'b0;
    tick();
    chk("wrun_idle", w_busy, 0);
    repeat (3) tick();
    chk("no_late_read", fdma_areq, 0);

    // zero-size write forwarded unchanged
    w_addr = 21'h1FFFFF; w_size = 16'd0; w_areq = 1'b1;
    tick();
    w_areq = 1'b0;
    chk("z_areq", fdma_areq, 1);
    chk("z_size", fdma_size, 0);
    chk("z_addr", fdma_addr, 21'h1FFFFF);
    fdma_busy = 1'b1; tick();
    fdma_busy = 1'b0; tick();

    // reset in R_RUN
    r_addr = 21'h123; r_size = 16'd7; r_areq = 1'b1;
    tick();
    r_areq = 1'b0;
    fdma_busy = 1'b1;
    #1;
    chk("rd_busy_req", r_busy, 1);
    tick();
    fdma_rvalid = 1'b1;
    fdma_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_rvalid", r_rvalid, 1);
    chk("rd_rdata",  r_rdata,  32'hDEAD_BEEF);
    ui_rst = 1'b1;
    #1;
    chk("mrst_areq",   fdma_areq, 0);
    chk("mrst_rnw",    fdma_rnw,  0);
    chk("mrst_addr",   fdma_addr, 0);
    chk("mrst_size",   fdma_size, 0);
    chk("mrst_rbusy",  r_busy,    0);
    chk("mrst_rvalid", r_rvalid,  0);
    chk("mrst_wbusy",  w_busy,    0);
    chk("mrst_wvalid", w_wvalid,  0);
    tick();
    fdma_busy = 1'b0; fdma_rvalid = 1'b0;
    ui_rst = 1'b0;
    w_addr = 21'h0AB; w_size = 16'd3; w_areq = 1'b1;
    tick();
    w_areq = 1'b0;
    chk("post_rst_areq", fdma_areq, 1);
    chk("post_rst_rnw",  fdma_rnw,  0);
    chk("post_rst_addr", fdma_addr, 21'h0AB);
    fdma_busy = 1'b1; tick();
    fdma_busy = 1'b0; tick();

`ifdef FDMA_ARB_STATS_EN
    ui_rst = 1'b1;
    tick();
    ui_rst = 1'b0;
    chk("stat_rst_wr", stat_wr_cnt, 0);
    for (int k = 0; k < 3; k++) do_one(1'b0, rnw);
    for (int k = 0; k < 5; k++) do_one(1'b1, rnw);
    tick();
    chk("stat_wr", stat_wr_cnt, 3);
    chk("stat_rd", stat_rd_cnt, 5);
`else
    do_one(1'b1, rnw);
    chk("solo_read_rnw", rnw, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
